// File: rtl/fp_adder_pipe.sv
// Pipelined IEEE-754 adder (RNE, full subnormal support). One input register
// followed by three compute stages (unpack/swap, align/add, normalise/round/pack).
module fp_adder_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_inexact
);
  localparam int STAGES = 3;
  localparam int XW     = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int SW     = XW + 1;     // plus carry-out
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_val;
    logic             spec_inv;
    logic             sign;
    logic             zsign;
    logic             sub;
    logic [EXP_W-1:0] exp_l;
    logic [MAN_W:0]   man_l;
    logic [MAN_W:0]   man_s;
    logic [EXP_W-1:0] diff;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_val;
    logic             spec_inv;
    logic             sign;
    logic             zsign;
    logic [EXP_W-1:0] exp_l;
    logic [SW-1:0]    sum;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  logic [W-1:0]    a_q, b_q;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    res_s;
  logic            res_inv, res_ovf, res_inx;
  logic            adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  function automatic logic [31:0] lzc(input logic [XW-1:0] v);
    lzc = 32'(XW);
    for (int i = 0; i < XW; i++)
      if (v[i]) lzc = 32'(XW - 1 - i);
  endfunction

  // S1: classify, order by magnitude, exponent difference
  logic [EXP_W-1:0] ea, eb, el_f, es_f, el, es;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;
  logic [W-1:0]     lw, sw;

  always_comb begin
    ea     = a_q[W-2 -: EXP_W];
    eb     = b_q[W-2 -: EXP_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    a_nan  = (ea == EXP_MAX) && (fa != '0);
    b_nan  = (eb == EXP_MAX) && (fb != '0);
    a_inf  = (ea == EXP_MAX) && (fa == '0);
    b_inf  = (eb == EXP_MAX) && (fb == '0);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    swap   = b_q[W-2:0] > a_q[W-2:0];
    lw     = swap ? b_q : a_q;
    sw     = swap ? a_q : b_q;
    el_f   = lw[W-2 -: EXP_W];
    es_f   = sw[W-2 -: EXP_W];
    el     = (el_f == '0) ? EXP_W'(1) : el_f;
    es     = (es_f == '0) ? EXP_W'(1) : es_f;

    s1_d          = '0;
    s1_d.sign     = lw[W-1];
    s1_d.zsign    = a_q[W-1] & b_q[W-1];
    s1_d.sub      = lw[W-1] ^ sw[W-1];
    s1_d.exp_l    = el;
    s1_d.man_l    = {el_f != '0, lw[MAN_W-1:0]};
    s1_d.man_s    = {es_f != '0, sw[MAN_W-1:0]};
    s1_d.diff     = el - es;
    if (a_nan || b_nan) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = QNAN;
      s1_d.spec_inv = a_snan | b_snan;
    end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = QNAN;
      s1_d.spec_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = a_inf ? a_q : b_q;
    end
  end

  // S2: align smaller operand, then add/subtract. Bits lost past the sticky
  // position are kept aside so the subtraction borrows correctly.
  logic [31:0]     diff32, sh;
  logic [XW-1:0]   ext_l, ext_s, aligned;
  logic [2*XW-1:0] wide;
  logic            lost;

  always_comb begin
    diff32  = 32'(s1_q.diff);
    sh      = (diff32 > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : diff32;
    ext_l   = {s1_q.man_l, 3'b000};
    ext_s   = {s1_q.man_s, 3'b000};
    wide    = {ext_s, {XW{1'b0}}} >> sh;
    aligned = wide[2*XW-1:XW];
    lost    = |wide[XW-1:0];

    s2_d          = '0;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.spec_inv = s1_q.spec_inv;
    s2_d.sign     = s1_q.sign;
    s2_d.zsign    = s1_q.zsign;
    s2_d.exp_l    = s1_q.exp_l;
    if (s1_q.sub) s2_d.sum = {1'b0, ext_l} - {1'b0, aligned} - SW'(lost);
    else          s2_d.sum = {1'b0, ext_l} + {1'b0, aligned};
    s2_d.sum[0] = s2_d.sum[0] | lost;
  end

  // S3: normalise (never below the minimum exponent), round, pack
  logic [SW-1:0]    r;
  logic [31:0]      lz, lim, shl;
  logic [XW-1:0]    n;
  logic [EXP_W:0]   e;
  logic             g, rs, up;
  logic [MAN_W+1:0] mr;
  logic [MAN_W:0]   mf;

  always_comb begin
    r   = s2_q.sum;
    lz  = lzc(r[XW-1:0]);
    lim = 32'(s2_q.exp_l) - 32'd1;
    shl = '0;
    if (r[SW-1]) begin
      n = r[SW-1:1] | XW'(r[0]);
      e = {1'b0, s2_q.exp_l} + (EXP_W+1)'(1);
    end else begin
      shl = (lz < lim) ? lz : lim;
      n   = r[XW-1:0] << shl;
      e   = {1'b0, s2_q.exp_l} - (EXP_W+1)'(shl);
    end
    g  = n[2];
    rs = n[1] | n[0];
    up = g & (rs | n[3]);
    mr = {1'b0, n[XW-1:3]} + (MAN_W+2)'(up);
    if (mr[MAN_W+1]) begin
      mf = mr[MAN_W+1:1];
      e  = e + (EXP_W+1)'(1);
    end else begin
      mf = mr[MAN_W:0];
    end

    res_inv = 1'b0;
    res_ovf = 1'b0;
    res_inx = 1'b0;
    if (s2_q.spec) begin
      res_s   = s2_q.spec_val;
      res_inv = s2_q.spec_inv;
    end else if (r == '0) begin
      res_s = {s2_q.zsign, {(W-1){1'b0}}};
    end else if (e >= {1'b0, EXP_MAX}) begin
      res_s   = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
      res_inx = 1'b1;
    end else begin
      // hidden bit clear at minimum exponent means a subnormal encoding
      res_s   = {s2_q.sign, mf[MAN_W] ? e[EXP_W-1:0] : {EXP_W{1'b0}}, mf[MAN_W-1:0]};
      res_inx = g | rs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe      <= '0;
      s             <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
    end else if (adv) begin
      vld_pipe      <= {vld_pipe[STAGES-1:0], in_valid};
      a_q           <= a;
      b_q           <= b;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s             <= res_s;
      flag_invalid  <= res_inv;
      flag_overflow <= res_ovf;
      flag_inexact  <= res_inx;
    end
  end
endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe (binary32): latency, RNE, specials,
// backpressure ordering and mid-flight reset.
module tb_fp_adder_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        flag_invalid, flag_overflow, flag_inexact;

  int checks = 0;
  int errors = 0;

  fp_adder_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_inexact(flag_inexact)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one isolated operation: accept at edge N, silent at N+2, result at N+3
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ex_s, input logic [2:0] ex_f);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "/early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "/valid"}, 32'(out_valid), 32'd1);
    check({tag, "/s"}, s, ex_s);
    check({tag, "/flags"}, 32'({flag_invalid, flag_overflow, flag_inexact}), 32'(ex_f));
    tick();
  endtask

  logic [31:0] fl [0:10];
  int          sent, recv, cyc;
  logic        acc, take, was_stall, stale;
  logic [31:0] hold_s;

  initial begin
    fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000,
           32'h41300000};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick(); tick();
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/s", s, 32'h0);
    check("rst/flags", 32'({flag_invalid, flag_overflow, flag_inexact}), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst/in_ready", 32'(in_ready), 32'd1);
    check("post_rst/out_valid", 32'(out_valid), 32'd0);

    // flags order: {invalid, overflow, inexact}
    run_op("1+1",         32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
    run_op("tie_even",    32'h3F800000, 32'h33800000, 32'h3F800000, 3'b001);
    run_op("tie_odd",     32'h3F800001, 32'h33800000, 32'h3F800002, 3'b001);
    run_op("x-x",         32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000);
    run_op("-0+-0",       32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
    run_op("sub+sub",     32'h00000001, 32'h00000001, 32'h00000002, 3'b000);
    run_op("inf-inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100);
    run_op("ovf",         32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b011);
    run_op("snan",        32'h7FA00000, 32'h3F800000, 32'h7FC00000, 3'b100);
    run_op("qnan",        32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000);
    run_op("inf+1",       32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000);
    run_op("1-2",         32'h3F800000, 32'hC0000000, 32'hBF800000, 3'b000);
    run_op("3-1",         32'h40400000, 32'hBF800000, 32'h40000000, 3'b000);
    run_op("-1-1",        32'hBF800000, 32'hBF800000, 32'hC0000000, 3'b000);
    run_op("minnorm-den", 32'h00800000, 32'h80000001, 32'h007FFFFF, 3'b000);
    run_op("2^24+1",      32'h4B800000, 32'h3F800000, 32'h4B800000, 3'b001);
    run_op("2^24+2",      32'h4B800000, 32'h40000000, 32'h4B800001, 3'b000);
    run_op("1+tiny",      32'h3F800000, 32'h00000001, 32'h3F800000, 3'b001);
    run_op("1-tiny",      32'h3F800000, 32'h80000001, 32'h3F800000, 3'b001);

    // backpressure: 10 back-to-back pairs, consumer stalls 4 cycles
    sent = 0; recv = 0; cyc = 0; was_stall = 1'b0; hold_s = '0;
    while (recv < 10 && cyc < 80) begin
      in_valid  = (sent < 10);
      a         = fl[0];
      b         = (sent < 10) ? fl[sent] : 32'h0;
      out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      if (was_stall) begin
        check("bp/hold_valid", 32'(out_valid), 32'd1);
        check("bp/hold_s", s, hold_s);
      end
      if (out_valid && !out_ready) check("bp/in_ready_low", 32'(in_ready), 32'd0);
      was_stall = out_valid && !out_ready;
      hold_s    = s;
      acc       = in_valid && in_ready;
      take      = out_valid && out_ready;
      if (take) begin
        check($sformatf("bp/s%0d", recv), s, fl[recv + 1]);
        recv++;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    check("bp/received", 32'(recv), 32'd10);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp/no_dup", 32'(out_valid), 32'd0);

    // reset with three results in flight
    in_valid = 1'b1; a = fl[0]; b = fl[0];
    tick(); tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    check("midrst/no_stale", 32'(stale), 32'd0);
    run_op("after_rst", 32'h40400000, 32'h40800000, 32'h40E00000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
